// File: rtl/fp_align_shifter.sv
// fp_align_shifter: exponent compare and mantissa alignment for FP add.
// Takes an operand pair, picks the larger-exponent operand as "big" and
// right-shifts the other into a {mantissa,G,R,S} field. The shift runs over
// several cycles with coarse-to-fine steps (16/4/1). Every bit that falls
// off the bottom is folded into the sticky bit.
module fp_align_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] exp_a,
  input  logic [10:0] exp_b,
  input  logic [52:0] mant_a,
  input  logic [52:0] mant_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] exp_out,
  output logic [52:0] mant_big,
  output logic [55:0] mant_small,
  output logic        swapped
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Beyond 56 every mantissa/GRS bit has already reached sticky, so the
  // remaining count saturates there and fits in 6 bits.
  localparam logic [5:0]  MAX_SHIFT = 6'd56;
  localparam logic [10:0] MAX_DIFF  = 11'd56;

  state_t      r_state;
  state_t      w_next;

  logic [10:0] r_exp;
  logic [52:0] r_big;
  logic [55:0] r_sh;
  logic [5:0]  r_rem;
  logic        r_swapped;

  logic        w_swap;
  logic [10:0] w_diff;
  logic [5:0]  w_rem_init;
  logic [52:0] w_small_in;
  logic [5:0]  w_step;
  logic [55:0] w_sh_next;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign exp_out    = r_exp;
  assign mant_big   = r_big;
  assign mant_small = r_sh;
  assign swapped    = r_swapped;

  // Operand ordering and saturated shift distance from the live inputs;
  // only consumed on the accepting edge.
  always_comb begin
    w_swap     = (exp_b > exp_a);
    w_diff     = w_swap ? (exp_b - exp_a) : (exp_a - exp_b);
    w_rem_init = (w_diff > MAX_DIFF) ? MAX_SHIFT : w_diff[5:0];
    w_small_in = w_swap ? mant_a : mant_b;
  end

  // One alignment step: largest step that does not overshoot, with all
  // discarded bits ORed into bit 0 so sticky can only ever set.
  always_comb begin
    w_step    = 6'd0;
    w_sh_next = r_sh;
    if (r_rem >= 6'd16) begin
      w_step       = 6'd16;
      w_sh_next    = r_sh >> 16;
      w_sh_next[0] = r_sh[16] | (|r_sh[15:0]);
    end else if (r_rem >= 6'd4) begin
      w_step       = 6'd4;
      w_sh_next    = r_sh >> 4;
      w_sh_next[0] = r_sh[4] | (|r_sh[3:0]);
    end else if (r_rem != 6'd0) begin
      w_step       = 6'd1;
      w_sh_next    = r_sh >> 1;
      w_sh_next[0] = r_sh[1] | r_sh[0];
    end
  end

  // Next-state: accept in IDLE, leave SHIFT once the count is exhausted,
  // leave DONE on consumer handshake. Handoff never overlaps acceptance
  // because IDLE is only reached after the handoff edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)     w_next = S_SHIFT;
      S_SHIFT: if (r_rem == 6'd0) w_next = S_DONE;
      S_DONE:  if (out_ready)    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; reset wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Datapath: capture on accept, step while shifting, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp     <= 11'd0;
      r_big     <= 53'd0;
      r_sh      <= 56'd0;
      r_rem     <= 6'd0;
      r_swapped <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_swapped <= w_swap;
            r_exp     <= w_swap ? exp_b  : exp_a;
            r_big     <= w_swap ? mant_b : mant_a;
            r_sh      <= {w_small_in, 3'b000};
            r_rem     <= w_rem_init;
          end
        end
        S_SHIFT: begin
          if (r_rem != 6'd0) begin
            r_sh  <= w_sh_next;
            r_rem <= r_rem - w_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
